// File: rtl/uart_rx_axis_fifo.sv
// uart_rx_axis_fifo
// Receives 8N1 UART frames, holds each received byte in a staging register
// until its packet boundary is known, then buffers it in a first-word
// fall-through FIFO that feeds an AXI-Stream master. A packet ends when the
// line has been idle for IDLE_BITS bit-times after the last byte.
//
// Ports:
//   clk          - the only clock
//   rst          - asynchronous reset, active low
//   uart_rx      - serial input, idles high, asynchronous to clk
//   m_axis_data  - head-of-FIFO byte (0 while the FIFO is empty)
//   m_axis_valid - FIFO holds at least one beat
//   m_axis_ready - consumer accepts the current beat
//   m_axis_last  - current beat ends a packet
//   overflow     - sticky, a byte was dropped because the FIFO was full
//   frame_err    - one-cycle pulse when a stop bit is sampled low
module uart_rx_axis_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int CLK_RATE  = 50000000,
  parameter int BAUD      = 115200,
  parameter int IDLE_BITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  output logic [WIDTH-1:0] m_axis_data,
  output logic             m_axis_valid,
  input  logic             m_axis_ready,
  output logic             m_axis_last,
  output logic             overflow,
  output logic             frame_err
);

  localparam int CLKS_PER_BIT = CLK_RATE / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int IDLE_LIMIT   = IDLE_BITS * CLKS_PER_BIT;
  localparam int AW           = $clog2(DEPTH);
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int BW           = $clog2(WIDTH + 1);
  localparam int IW           = $clog2(IDLE_LIMIT + 1);

  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(WIDTH - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state;
  logic [CW-1:0]    clk_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [IW-1:0]    idle_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] stage;
  logic             stage_v;

  logic             rx_meta;
  logic             rx_s;
  logic             rx_prev;
  logic             fall;

  logic             start_ok;
  logic             stop_sample;
  logic             push_start;
  logic             push_idle;
  logic             push_en;
  logic [WIDTH:0]   push_word;

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH:0]   head;
  logic             full;
  logic             empty;
  logic             pop;

  // Synchronizer plus one history stage for edge detection. These reset low
  // so that a line already low at reset release produces no falling edge:
  // the line has to return high and fall again before a frame is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

  // A validated start bit flushes the staged byte as a mid-packet beat; an
  // idle timeout flushes it as the packet's final beat. The two live in
  // different states, so at most one fires in a cycle.
  assign start_ok    = (state == S_START) && (clk_cnt == HALF_LAST) && !rx_s;
  assign stop_sample = (state == S_STOP) && (clk_cnt == BIT_LAST);
  assign push_start  = start_ok && stage_v;
  assign push_idle   = (state == S_IDLE) && stage_v && !fall && (idle_cnt == IDLE_LAST);
  assign push_en     = push_start | push_idle;
  assign push_word   = {push_idle, stage};

  // Receiver state machine, staging register and idle-gap counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      shift_reg <= '0;
      stage     <= '0;
      stage_v   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      if (fall || stop_sample) begin
        idle_cnt <= '0;
      end else if ((state == S_IDLE) && stage_v) begin
        idle_cnt <= push_idle ? '0 : idle_cnt + IW'(1);
      end

      case (state)
        S_IDLE: begin
          if (fall) begin
            state   <= S_START;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end
          if (push_idle) begin
            stage_v <= 1'b0;
          end
        end

        S_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              state <= S_DATA;
              if (stage_v) begin
                stage_v <= 1'b0;
              end
            end else begin
              state <= S_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt   <= '0;
            shift_reg <= {rx_s, shift_reg[WIDTH-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            state   <= S_IDLE;
            if (rx_s) begin
              stage   <= shift_reg;
              stage_v <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && m_axis_ready;

  // Fullness is judged before this cycle's pop, so a push into a full FIFO
  // is dropped even when a pop frees a slot in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_en) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + (AW+1)'(1);
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (push_en && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_word;
    end
  end

  // First-word fall-through head; outputs read as zero while empty so reset
  // clears them without resetting the storage array.
  assign head         = mem[rd_ptr[AW-1:0]];
  assign m_axis_valid = !empty;
  assign m_axis_data  = empty ? '0 : head[WIDTH-1:0];
  assign m_axis_last  = !empty && head[WIDTH];

endmodule

// File: doc/uart_rx_axis_fifo.md
# uart_rx_axis_fifo

Receive-side counterpart of the AXIS-to-UART transmit path. Deserialises an 8N1 UART line, buffers the received bytes in a FIFO and presents them as an AXI-Stream master. Packet boundaries (`m_axis_last`) are set by line-idle timeout. It sits at the board RX pin and feeds downstream stream consumers, closing the loop with `axis_fifo_uart_tx`.

## Interface
- `WIDTH`, 8: data bits per UART frame and per AXIS beat.
- `DEPTH`, 8: number of FIFO entries; must be a power of two.
- `CLK_RATE`, 50000000: clock frequency in Hz.
- `BAUD`, 115200: line rate. `CLKS_PER_BIT = CLK_RATE/BAUD`, integer divide, which gives 434 at the defaults.
- `IDLE_BITS`, 16: length of the idle gap, in bit-times, that terminates a packet.

Ports:
- `clk`  in  1: the only clock.
- `rst`  in  1: asynchronous, active-low reset.
- `uart_rx`  in  1: serial input, idles high, asynchronous to `clk`.
- `m_axis_data`  out  WIDTH: received byte.
- `m_axis_valid`  out  1: FIFO head is valid.
- `m_axis_ready`  in  1: consumer accepts the beat.
- `m_axis_last`  out  1: this beat ends the packet.
- `overflow`  out  1: sticky flag, set when a byte is dropped because the FIFO was full; cleared only by reset.
- `frame_err`  out  1: one-cycle pulse when a stop bit is sampled low.

## Operation
- `uart_rx` passes through a 2-FF synchronizer. All RX logic uses the synchronized signal `rx_s`.

Receiver FSM:
- **IDLE**: a falling edge on `rx_s` moves to START and clears the bit counter.
- **START**: at `CLKS_PER_BIT/2` cycles, if `rx_s` is low, go to DATA. If `rx_s` is high, treat it as a glitch and return to IDLE.
- **DATA**: sample every `CLKS_PER_BIT` cycles, LSB first, into a shift register. After `WIDTH` samples, go to STOP.
- **STOP**: sample once at mid-bit.
  - High: load the byte into the staging register and set `stage_v`.
  - Low: pulse `frame_err` and discard the byte; `stage_v` is unchanged.
  - Either way, return to IDLE.

Staging register and packet delimiting:
- The received byte is held in staging so its `last` bit can be decided before it is pushed.
- When a new start bit is validated (START to DATA) and `stage_v=1`: push `{last=0, stage}` and clear `stage_v`.
- Idle counter:
  - Runs only in IDLE with `stage_v=1`.
  - Cleared on any STOP sample and on any falling edge.
  - When it reaches `IDLE_BITS*CLKS_PER_BIT`: push `{last=1, stage}` and clear `stage_v`.
- Only one push source can fire in any cycle.

FIFO:
- `DEPTH` entries, each `WIDTH+1` bits wide.
- Read and write pointers are `log2(DEPTH)+1` bits wide and wrap naturally. Full is decided by the MSB-differ test; empty is pointers equal.
- First-word fall-through: `m_axis_valid = !empty`, and `m_axis_data`/`m_axis_last` drive the head entry.
- A pop occurs on `m_axis_valid && m_axis_ready`.
- Push while full:
  - Fullness is judged on the pre-cycle state, so a push is dropped even if a pop happens in the same cycle.
  - The dropped entry is discarded and `overflow` is set.
  - A dropped `last=1` entry loses that packet boundary.
- Push and pop in the same cycle when not full: both happen, and the occupancy is unchanged.
- The AXIS rule is not stated as an exception: once `m_axis_valid` is high, data, last and valid stay stable until the beat is accepted. FIFO head stability guarantees this.

Reset (`rst` low, applied asynchronously):
- FSM goes to IDLE; pointers, counters and `stage_v` clear to 0.
- `m_axis_valid`=0, `m_axis_last`=0, `m_axis_data`=0, `overflow`=0, `frame_err`=0.
- Reset in the middle of a frame abandons that frame. After reset releases, the line must be seen idle (a falling edge is required) before a new frame is accepted.

## Timing
- Synchronizer latency: 2 cycles.
- Start validation: `CLKS_PER_BIT/2` cycles after the synchronized falling edge.
- Stop sample: at `(WIDTH+1)*CLKS_PER_BIT + CLKS_PER_BIT/2` cycles after the falling edge.
- A byte followed by another byte becomes visible on AXIS 1 cycle after the next start is validated.
- The final byte of a burst becomes visible 1 cycle after the idle timeout. With defaults, that is 6944 cycles after its stop sample.
- Push to `m_axis_valid`: the registered pointer update makes valid visible the next cycle.
- `m_axis_ready` may stay high continuously; sustained throughput is 1 beat per cycle.

## Test plan
- **Single byte**: send 0xA5, line then idle. Expect exactly 1 beat, data=0xA5, last=1, appearing 6944±2 cycles after the stop mid-bit; `frame_err`=0.
- **Burst**: send 0x01, 0x02, 0x03 back-to-back with `m_axis_ready`=1. Expect beats 01(last=0), 02(last=0), 03(last=1), in order.
- **Backpressure and overflow**: hold `m_axis_ready`=0 and send 10 bytes 0x10..0x19 back-to-back. Expect:
  - `overflow` goes high on the 9th push.
  - After ready is raised, 8 beats 0x10..0x17 come out, all with last=0.
  - 0x18 is lost; 0x19 stays staged and then emerges with last=1.
- **Framing error**: send 0x5A with a low stop bit. Expect a `frame_err` pulse for 1 cycle, no beat, and no change to `overflow`.
- **Glitch**: a 100-cycle low pulse on `uart_rx`. Expect the FSM to return to IDLE, no beat, and no `frame_err`.
- **Reset mid-frame**: assert `rst` low during DATA of 0x3C, release, then send 0xC3. Expect only 0xC3 (last=1), and all outputs 0 while reset is held.
